// File: rtl/adc_acq_if.sv
// Control / sample-stream bundle of the ADC acquisition controller.
// The slave modport belongs to the controller; the master modport belongs to the
// fabric side that starts bursts and consumes samples.
interface adc_acq_if #(
    parameter int CNT_W     = 16,
    parameter int DATA_BITS = 18
);
    logic                 start;
    logic                 stop;
    logic [CNT_W-1:0]     num_samples;
    logic [DATA_BITS-1:0] sample_data;
    logic                 sample_valid;
    logic                 sample_ready;
    logic                 busy;
    logic                 done;
    logic                 overrun;

    modport master (
        output start, stop, num_samples, sample_ready,
        input  sample_data, sample_valid, busy, done, overrun
    );

    modport slave (
        input  start, stop, num_samples, sample_ready,
        output sample_data, sample_valid, busy, done, overrun
    );
endinterface

// File: rtl/adc_acq_controller.sv
// Serial SAR ADC burst sequencer.
// Owns cnv / adc_clk timing, shifts adc_sdo in MSB first and hands each sample
// to a valid/ready stream. A single period counter (pcnt) is the time base:
// every event in a conversion is a fixed pcnt value, so the cnv rate is exact.
// Optional feature: define ADC_ACQ_DROP_CNT_EN to add the saturating drop_cnt output.
module adc_acq_controller #(
    parameter int PERIOD     = 640,
    parameter int CNV_WIDTH  = 4,
    parameter int CONV_DELAY = 84,
    parameter int SCK_HALF   = 1,
    parameter int DATA_BITS  = 18,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       reset,
    adc_acq_if.slave   ctl,
    input  logic       adc_sdo,
    output logic       cnv,
    output logic       adc_clk
`ifdef ADC_ACQ_DROP_CNT_EN
    ,
    output logic [CNT_W-1:0] drop_cnt
`endif
);

    localparam int PCNT_W = $clog2(PERIOD);
    localparam int HALF_W = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    // pcnt landmarks (value of pcnt during the cycle in which the action is registered)
    localparam logic [PCNT_W-1:0] CNV_END   = PCNT_W'(CNV_WIDTH);
    localparam logic [PCNT_W-1:0] WAIT_END  = PCNT_W'(CONV_DELAY);
    // last adc_clk fall becomes visible at CONV_DELAY+1+2*SCK_HALF*DATA_BITS-SCK_HALF;
    // the output register loads on the edge that closes the following cycle
    localparam logic [PCNT_W-1:0] LOAD_AT   = PCNT_W'(CONV_DELAY + 2*SCK_HALF*DATA_BITS - SCK_HALF + 2);
    localparam logic [PCNT_W-1:0] DECIDE_AT = PCNT_W'(PERIOD - 2);
    localparam logic [PCNT_W-1:0] LAST      = PCNT_W'(PERIOD - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(SCK_HALF - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CNV   = 3'd1,
        S_WAIT  = 3'd2,
        S_SHIFT = 3'd3,
        S_GAP   = 3'd4,
        S_END   = 3'd5
    } state_t;

    state_t               state_r;
    logic [PCNT_W-1:0]    pcnt_r;
    logic [HALF_W-1:0]    half_r;
    logic [BIT_W-1:0]     bit_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [CNT_W-1:0]     scnt_r;
    logic [CNT_W-1:0]     num_r;
    logic                 stop_seen_r;
    logic                 cnv_r;
    logic                 adc_clk_r;
    logic                 busy_r;
    logic                 done_r;

    logic [DATA_BITS-1:0] data_r;
    logic                 valid_r;
    logic                 overrun_r;

    logic                 accept_s;
    logic                 load_s;
    logic                 last_conv_s;
    logic [PCNT_W-1:0]    pcnt_inc_s;

    // Start qualification, load strobe, end-of-burst condition and wrapping pcnt increment
    always_comb begin
        accept_s    = 1'b0;
        load_s      = 1'b0;
        last_conv_s = 1'b0;
        pcnt_inc_s  = {PCNT_W{1'b0}};
        if ((state_r == S_IDLE) && ctl.start && !ctl.stop) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        if ((state_r == S_GAP) && (pcnt_r == LOAD_AT)) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
        if (stop_seen_r || ctl.stop ||
            ((num_r != {CNT_W{1'b0}}) && (scnt_r == num_r))) begin
            last_conv_s = 1'b1;
        end else begin
            last_conv_s = 1'b0;
        end
        if (pcnt_r == LAST) begin
            pcnt_inc_s = {PCNT_W{1'b0}};
        end else begin
            pcnt_inc_s = pcnt_r + PCNT_W'(1);
        end
    end

    // Burst sequencer: period counter, cnv / adc_clk generation, serial shift-in, busy/done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= S_IDLE;
            pcnt_r      <= {PCNT_W{1'b0}};
            half_r      <= {HALF_W{1'b0}};
            bit_r       <= {BIT_W{1'b0}};
            shift_r     <= {DATA_BITS{1'b0}};
            scnt_r      <= {CNT_W{1'b0}};
            num_r       <= {CNT_W{1'b0}};
            stop_seen_r <= 1'b0;
            cnv_r       <= 1'b0;
            adc_clk_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    cnv_r     <= 1'b0;
                    adc_clk_r <= 1'b0;
                    done_r    <= 1'b0;
                    if (accept_s) begin
                        state_r     <= S_CNV;
                        pcnt_r      <= {PCNT_W{1'b0}};
                        busy_r      <= 1'b1;
                        num_r       <= ctl.num_samples;
                        scnt_r      <= CNT_W'(1);
                        stop_seen_r <= 1'b0;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                S_CNV: begin
                    pcnt_r      <= pcnt_inc_s;
                    stop_seen_r <= stop_seen_r | ctl.stop;
                    // cnv lags pcnt by one cycle: high while pcnt reads 1..CNV_WIDTH
                    cnv_r       <= (pcnt_r < CNV_END);
                    if (pcnt_r == CNV_END) begin
                        state_r <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    pcnt_r      <= pcnt_inc_s;
                    stop_seen_r <= stop_seen_r | ctl.stop;
                    cnv_r       <= 1'b0;
                    if (pcnt_r == WAIT_END) begin
                        // first rising edge of adc_clk; MSB captured on this edge
                        state_r   <= S_SHIFT;
                        adc_clk_r <= 1'b1;
                        shift_r   <= {shift_r[DATA_BITS-2:0], adc_sdo};
                        half_r    <= {HALF_W{1'b0}};
                        bit_r     <= {BIT_W{1'b0}};
                    end
                end
                S_SHIFT: begin
                    pcnt_r      <= pcnt_inc_s;
                    stop_seen_r <= stop_seen_r | ctl.stop;
                    if (half_r == HALF_LAST) begin
                        half_r <= {HALF_W{1'b0}};
                        if (adc_clk_r) begin
                            adc_clk_r <= 1'b0;
                            if (bit_r == BIT_LAST) begin
                                state_r <= S_GAP;
                            end
                        end else begin
                            adc_clk_r <= 1'b1;
                            shift_r   <= {shift_r[DATA_BITS-2:0], adc_sdo};
                            bit_r     <= bit_r + BIT_W'(1);
                        end
                    end else begin
                        half_r <= half_r + HALF_W'(1);
                    end
                end
                S_GAP: begin
                    stop_seen_r <= stop_seen_r | ctl.stop;
                    if ((pcnt_r == DECIDE_AT) && last_conv_s) begin
                        // busy drops and done pulses on the final cycle of the last period
                        state_r <= S_END;
                        pcnt_r  <= pcnt_inc_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else if (pcnt_r == LAST) begin
                        // a stop in this cycle belongs to the conversion that starts now
                        state_r     <= S_CNV;
                        pcnt_r      <= {PCNT_W{1'b0}};
                        scnt_r      <= scnt_r + CNT_W'(1);
                        stop_seen_r <= ctl.stop;
                    end else begin
                        pcnt_r <= pcnt_inc_s;
                    end
                end
                S_END: begin
                    state_r     <= S_IDLE;
                    pcnt_r      <= {PCNT_W{1'b0}};
                    done_r      <= 1'b0;
                    busy_r      <= 1'b0;
                    stop_seen_r <= 1'b0;
                end
                default: begin
                    state_r   <= S_IDLE;
                    pcnt_r    <= {PCNT_W{1'b0}};
                    cnv_r     <= 1'b0;
                    adc_clk_r <= 1'b0;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                end
            endcase
        end
    end

    // Output slot: load a finished sample unless the previous one is still pending and not taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r  <= {DATA_BITS{1'b0}};
            valid_r <= 1'b0;
        end else if (load_s && !(valid_r && !ctl.sample_ready)) begin
            data_r  <= shift_r;
            valid_r <= 1'b1;
        end else if (valid_r && ctl.sample_ready) begin
            valid_r <= 1'b0;
        end
    end

    // Sticky overrun flag, cleared when a new burst is accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_r <= 1'b0;
        end else if (accept_s) begin
            overrun_r <= 1'b0;
        end else if (load_s && valid_r && !ctl.sample_ready) begin
            overrun_r <= 1'b1;
        end
    end

`ifdef ADC_ACQ_DROP_CNT_EN
    logic [CNT_W-1:0] drop_r;

    // Saturating count of dropped samples, cleared when a new burst is accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            drop_r <= {CNT_W{1'b0}};
        end else if (load_s && valid_r && !ctl.sample_ready &&
                     (drop_r != {CNT_W{1'b1}})) begin
            drop_r <= drop_r + CNT_W'(1);
        end
    end

    assign drop_cnt = drop_r;
`endif

    assign cnv              = cnv_r;
    assign adc_clk          = adc_clk_r;
    assign ctl.busy         = busy_r;
    assign ctl.done         = done_r;
    assign ctl.sample_data  = data_r;
    assign ctl.sample_valid = valid_r;
    assign ctl.overrun      = overrun_r;

endmodule

// File: tb/tb_adc_acq_controller.sv
// Directed bench for adc_acq_controller: one default instance (18-bit, SCK_HALF=1)
// and one SCK_HALF=2 / 16-bit instance. Negedge monitors record pulse timing and
// transfers; the main sequence compares them against hand-computed values.
module tb_adc_acq_controller;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    adc_acq_if #(.CNT_W(16), .DATA_BITS(18)) bus1 ();
    adc_acq_if #(.CNT_W(16), .DATA_BITS(16)) bus2 ();

    logic sdo1, cnv1, sck1, sdo2, cnv2, sck2;
    logic [15:0] drop1, drop2;

    adc_acq_controller dut1 (
        .clk(clk), .reset(reset), .ctl(bus1.slave),
        .adc_sdo(sdo1), .cnv(cnv1), .adc_clk(sck1)
`ifdef ADC_ACQ_DROP_CNT_EN
        , .drop_cnt(drop1)
`endif
    );

    adc_acq_controller #(.SCK_HALF(2), .DATA_BITS(16)) dut2 (
        .clk(clk), .reset(reset), .ctl(bus2.slave),
        .adc_sdo(sdo2), .cnv(cnv2), .adc_clk(sck2)
`ifdef ADC_ACQ_DROP_CNT_EN
        , .drop_cnt(drop2)
`endif
    );

`ifndef ADC_ACQ_DROP_CNT_EN
    assign drop1 = 16'd0;
    assign drop2 = 16'd0;
`endif

    // ---------------- monitor / ADC model, instance 1 ----------------
    int cnv_n, cnv_first, cnv_last, cnv_w, cnv_wmin, cnv_wmax;
    int sck_n, sck_first, sck_last, sck_w, hi_min, hi_max, rr_min, rr_max, d1;
    int done_n, done_cyc, x_n, x_first;
    logic [17:0] x_data;
    int bi1, ci1;
    bit mode1;
    logic p_cnv1 = 1'b0, p_sck1 = 1'b0;
    logic [17:0] word1;

    assign word1 = mode1 ? (18'h2A5A5 + 18'(ci1)) : 18'h2A5A5;
    assign sdo1  = (bi1 < 18) ? word1[17 - bi1] : 1'b0;

    always @(negedge clk) begin
        if (cnv1 && !p_cnv1) begin
            cnv_n++;
            if (cnv_n == 1) cnv_first = cyc;
            cnv_last = cyc;
            bi1 = 0;
            ci1++;
            cnv_w = 0;
        end
        if (cnv1) cnv_w++;
        if (!cnv1 && p_cnv1) begin
            if (cnv_w < cnv_wmin) cnv_wmin = cnv_w;
            if (cnv_w > cnv_wmax) cnv_wmax = cnv_w;
        end
        if (sck1 && !p_sck1) begin
            sck_n++;
            if (sck_n == 1) sck_first = cyc;
            else begin
                d1 = cyc - sck_last;
                if (d1 < 100) begin
                    if (d1 < rr_min) rr_min = d1;
                    if (d1 > rr_max) rr_max = d1;
                end
            end
            sck_last = cyc;
            bi1++;
            sck_w = 0;
        end
        if (sck1) sck_w++;
        if (!sck1 && p_sck1) begin
            if (sck_w < hi_min) hi_min = sck_w;
            if (sck_w > hi_max) hi_max = sck_w;
        end
        if (bus1.done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (bus1.sample_valid && bus1.sample_ready) begin
            x_n++;
            if (x_n == 1) x_first = cyc;
            x_data = bus1.sample_data;
        end
        p_cnv1 = cnv1;
        p_sck1 = sck1;
    end

    // ---------------- monitor / ADC model, instance 2 ----------------
    int cnv2_first, sck2_n, sck2_first, sck2_last, sck2_w, hi2_min, hi2_max, rr2_min, rr2_max, d2;
    int done2_n, done2_cyc, x2_n, bi2;
    logic [15:0] x2_data;
    logic [15:0] word2;
    logic p_cnv2 = 1'b0, p_sck2 = 1'b0;

    assign word2 = 16'hAAAA;
    assign sdo2  = (bi2 < 16) ? word2[15 - bi2] : 1'b0;

    always @(negedge clk) begin
        if (cnv2 && !p_cnv2) begin
            cnv2_first = cyc;
            bi2 = 0;
        end
        if (sck2 && !p_sck2) begin
            sck2_n++;
            if (sck2_n == 1) sck2_first = cyc;
            else begin
                d2 = cyc - sck2_last;
                if (d2 < rr2_min) rr2_min = d2;
                if (d2 > rr2_max) rr2_max = d2;
            end
            sck2_last = cyc;
            bi2++;
            sck2_w = 0;
        end
        if (sck2) sck2_w++;
        if (!sck2 && p_sck2) begin
            if (sck2_w < hi2_min) hi2_min = sck2_w;
            if (sck2_w > hi2_max) hi2_max = sck2_w;
        end
        if (bus2.done) begin
            done2_n++;
            done2_cyc = cyc;
        end
        if (bus2.sample_valid && bus2.sample_ready) begin
            x2_n++;
            x2_data = bus2.sample_data;
        end
        p_cnv2 = cnv2;
        p_sck2 = sck2;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        cnv_n = 0; cnv_first = 0; cnv_last = 0; cnv_w = 0; cnv_wmin = 9999; cnv_wmax = 0;
        sck_n = 0; sck_first = 0; sck_last = 0; sck_w = 0; hi_min = 9999; hi_max = 0;
        rr_min = 9999; rr_max = 0; done_n = 0; done_cyc = 0; x_n = 0; x_first = 0;
        x_data = 18'h0; bi1 = 18; ci1 = -1;
        cnv2_first = 0; sck2_n = 0; sck2_first = 0; sck2_last = 0; sck2_w = 0;
        hi2_min = 9999; hi2_max = 0; rr2_min = 9999; rr2_max = 0;
        done2_n = 0; done2_cyc = 0; x2_n = 0; x2_data = 16'h0; bi2 = 16;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // returns the cycle number right after the accepting edge (pcnt = 0)
    task automatic start1(input logic [15:0] num, output int t);
        @(negedge clk);
        bus1.num_samples = num;
        bus1.start = 1'b1;
        t = cyc + 1;
        @(negedge clk);
        bus1.start = 1'b0;
    endtask

    int t;

    initial begin
        reset = 1'b1;
        mode1 = 1'b0;
        bus1.start = 1'b0; bus1.stop = 1'b0; bus1.num_samples = 16'd0; bus1.sample_ready = 1'b1;
        bus2.start = 1'b0; bus2.stop = 1'b0; bus2.num_samples = 16'd0; bus2.sample_ready = 1'b1;
        clr();
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_cnv", {31'd0, cnv1}, 32'd0);
        chk("rst_sck", {31'd0, sck1}, 32'd0);
        chk("rst_busy", {31'd0, bus1.busy}, 32'd0);
        chk("rst_done", {31'd0, bus1.done}, 32'd0);
        chk("rst_valid", {31'd0, bus1.sample_valid}, 32'd0);
        chk("rst_ovr", {31'd0, bus1.overrun}, 32'd0);
        chk("rst_data", {14'd0, bus1.sample_data}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1: three-sample burst, consumer always ready
        clr();
        start1(16'd3, t);
        chk("t1_busy", {31'd0, bus1.busy}, 32'd1);
        wait_cyc(t + 2000);
        chk("t1_cnv_n", cnv_n, 3);
        chk("t1_cnv_first", cnv_first, t + 1);
        chk("t1_cnv_span", cnv_last - cnv_first, 1280);
        chk("t1_cnv_wmin", cnv_wmin, 4);
        chk("t1_cnv_wmax", cnv_wmax, 4);
        chk("t1_sck_n", sck_n, 54);
        chk("t1_sck_delay", sck_first - cnv_first, 84);
        chk("t1_sck_hi_min", hi_min, 1);
        chk("t1_sck_hi_max", hi_max, 1);
        chk("t1_sck_rr_min", rr_min, 2);
        chk("t1_sck_rr_max", rr_max, 2);
        chk("t1_x_n", x_n, 3);
        chk("t1_x_first", x_first, t + 122);
        chk("t1_x_data", {14'd0, x_data}, 32'h2A5A5);
        chk("t1_done_n", done_n, 1);
        chk("t1_done_cyc", done_cyc, t + 1919);
        chk("t1_busy_end", {31'd0, bus1.busy}, 32'd0);
        chk("t1_ovr", {31'd0, bus1.overrun}, 32'd0);

        // 2: consumer stalled for the whole burst, samples differ per conversion
        clr();
        mode1 = 1'b1;
        bus1.sample_ready = 1'b0;
        start1(16'd3, t);
        wait_cyc(t + 2000);
        chk("t2_x_n", x_n, 0);
        chk("t2_valid", {31'd0, bus1.sample_valid}, 32'd1);
        chk("t2_data", {14'd0, bus1.sample_data}, 32'h2A5A5);
        chk("t2_ovr", {31'd0, bus1.overrun}, 32'd1);
        chk("t2_done_n", done_n, 1);
`ifdef ADC_ACQ_DROP_CNT_EN
        chk("t2_drop", {16'd0, drop1}, 32'd2);
`endif
        @(negedge clk);
        bus1.sample_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("t2_x_n_after", x_n, 1);
        chk("t2_x_data", {14'd0, x_data}, 32'h2A5A5);
        chk("t2_valid_after", {31'd0, bus1.sample_valid}, 32'd0);

        // 3: continuous burst, stop pulsed in the SHIFT phase of conversion 5
        clr();
        start1(16'd0, t);
        chk("t3_ovr_clr", {31'd0, bus1.overrun}, 32'd0);
        wait_cyc(t + 2655);
        bus1.stop = 1'b1;
        @(negedge clk);
        bus1.stop = 1'b0;
        wait_cyc(t + 3400);
        chk("t3_cnv_n", cnv_n, 5);
        chk("t3_done_n", done_n, 1);
        chk("t3_done_cyc", done_cyc, t + 3199);
        chk("t3_x_n", x_n, 5);
        chk("t3_x_data", {14'd0, x_data}, 32'h2A5A9);
        chk("t3_busy", {31'd0, bus1.busy}, 32'd0);

        // 4: reset in the SHIFT phase of conversion 2 while sample 1 is pending
        clr();
        mode1 = 1'b0;
        bus1.sample_ready = 1'b0;
        start1(16'd3, t);
        wait_cyc(t + 731);
        chk("t4_pre_valid", {31'd0, bus1.sample_valid}, 32'd1);
        chk("t4_pre_sck", {31'd0, sck1}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("t4_cnv", {31'd0, cnv1}, 32'd0);
        chk("t4_sck", {31'd0, sck1}, 32'd0);
        chk("t4_busy", {31'd0, bus1.busy}, 32'd0);
        chk("t4_valid", {31'd0, bus1.sample_valid}, 32'd0);
        chk("t4_done", {31'd0, bus1.done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        clr();
        repeat (700) @(negedge clk);
        chk("t4_no_done", done_n, 0);
        chk("t4_no_cnv", cnv_n, 0);
        bus1.sample_ready = 1'b1;
        start1(16'd1, t);
        wait_cyc(t + 800);
        chk("t4_cnv_n", cnv_n, 1);
        chk("t4_sck_n", sck_n, 18);
        chk("t4_x_n", x_n, 1);
        chk("t4_x_data", {14'd0, x_data}, 32'h2A5A5);
        chk("t4_done_cyc", done_cyc, t + 639);

        // 5: start while busy, then start together with stop in IDLE
        clr();
        start1(16'd2, t);
        wait_cyc(t + 9);
        bus1.num_samples = 16'd5;
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        wait_cyc(t + 1400);
        chk("t5_cnv_n", cnv_n, 2);
        chk("t5_cnv_span", cnv_last - cnv_first, 640);
        chk("t5_done_n", done_n, 1);
        chk("t5_done_cyc", done_cyc, t + 1279);
        clr();
        @(negedge clk);
        bus1.num_samples = 16'd1;
        bus1.start = 1'b1;
        bus1.stop = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        bus1.stop = 1'b0;
        chk("t5_ss_busy", {31'd0, bus1.busy}, 32'd0);
        repeat (700) @(negedge clk);
        chk("t5_ss_cnv_n", cnv_n, 0);
        chk("t5_ss_done_n", done_n, 0);

        // 6: SCK_HALF=2, 16-bit instance, alternating data
        clr();
        @(negedge clk);
        bus2.num_samples = 16'd1;
        bus2.start = 1'b1;
        t = cyc + 1;
        @(negedge clk);
        bus2.start = 1'b0;
        wait_cyc(t + 800);
        chk("t6_x_n", x2_n, 1);
        chk("t6_x_data", {16'd0, x2_data}, 32'hAAAA);
        chk("t6_sck_n", sck2_n, 16);
        chk("t6_sck_rr_min", rr2_min, 4);
        chk("t6_sck_rr_max", rr2_max, 4);
        chk("t6_sck_hi_min", hi2_min, 2);
        chk("t6_sck_hi_max", hi2_max, 2);
        chk("t6_sck_delay", sck2_first - cnv2_first, 84);
        chk("t6_done_n", done2_n, 1);
        chk("t6_done_cyc", done2_cyc, t + 639);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
